ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
// - Upstream of the game top: turns a raw PS/2 keyboard line into the level-held 8-bit scan code
//   that feeds i_key_1 / i_key_2 (one instance per keyboard).
// - Handles 11-bit frames, the E0 extended prefix and the F0 break prefix.
// - o_key holds the most recently pressed key while it is down, and 8'h00 once it is released.
// PARAMETERS
// - SYNC_STAGES   2       flops in the synchroniser for i_ps2_clk and i_ps2_data (>=2)
// - TIMEOUT_CYC   50000   i_clk cycles with no PS/2 clock edge mid-frame before the frame is aborted (1 ms @ 50 MHz)
// PORTS
// - i_clk         in   1   system clock; one clock domain
// - i_rst         in   1   asynchronous, active-high reset
// - i_ps2_clk     in   1   raw PS/2 clock, asynchronous, idles high
// - i_ps2_data    in   1   raw PS/2 data, asynchronous, idles high
// - o_key         out  8   held scan code of the current key; 8'h00 = none
// - o_ext         out  1   o_key came from an E0-prefixed sequence
// - o_make        out  1   1-cycle pulse on every make code, including typematic repeats
// - o_break       out  1   1-cycle pulse on every break code, whether or not it matches o_key
// - o_frame_err   out  1   1-cycle pulse when a frame is dropped (bad start, parity or stop bit)
// BEHAVIOUR
// - Reset: all outputs 0; synchroniser flops set to 1 (idle, so no false edge); bit count 0; byte FSM in B_IDLE.
// - Sampling: PS/2 data is sampled on a synchronised falling edge of i_ps2_clk (previous=1, current=0).
// - Frame format: bit0 start=0, bits1..8 data LSB first, bit9 odd parity, bit10 stop=1; bit count runs 0..10.
//   - Start bit sampled as 1: not counted; stays at count 0; no error pulse.
//   - Bad parity or stop=0 at bit10: byte discarded, o_frame_err pulses, count returns to 0.
// - Timeout: count != 0 and no falling edge for TIMEOUT_CYC consecutive cycles -> count=0, partial byte dropped,
//   no error pulse. The watchdog restarts on every falling edge.
// - Latency: the receiver issues an internal byte strobe 1 cycle after the edge that samples the stop bit.
//   o_key / o_ext / o_make / o_break change on the cycle after that strobe, i.e. 2 cycles after the edge.
// - Byte FSM {B_IDLE, B_EXT, B_BRK}; internal flag ext_f, cleared whenever the FSM enters B_IDLE.
//   - B_IDLE + E0 -> B_EXT, ext_f=1.
//   - B_IDLE/B_EXT + F0 -> B_BRK; ext_f is kept.
//   - B_IDLE/B_EXT + other code -> make: o_key=code, o_ext=ext_f, o_make=1, -> B_IDLE.
//   - B_BRK + code -> break: o_break=1; if code==o_key and ext_f==o_ext then o_key=00, o_ext=0; -> B_IDLE.
//   - Bytes E1, FA (ack), AA (BAT ok), EE, FE, 00 and FF are ignored in every state; the state is unchanged.
// - Roll-over: a new make overwrites o_key. A break of an older key does not clear the newer one.
//   Example: press 75, press 72, release 75 -> o_key stays 72.
// - Repeat: a typematic make of the held key leaves o_key unchanged and pulses o_make again.
// - Outputs are registered; o_key is stable between bytes, so consumers may compare it combinationally.
// - Reset asserted mid-frame or mid-sequence: everything returns to reset values; the next complete frame
//   decodes normally.
// - A frame in flight when reset deasserts is lost: falling edges seen with count 0 are treated as start-bit
//   candidates, and a data bit of 1 is rejected as a bad start; a 0 data bit may start a false frame, which
//   the timeout or the parity check recovers.
// STRUCTURE
// - Shared package ps2_pkg:
//   - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_ACK=8'hFA, PS2_BAT=8'hAA
//   - game keys KEY_UP=8'h75, KEY_DOWN=8'h72, KEY_ENTER=8'h5A, KEY_ESC=8'h76
//   - typedef enum byte_state_t {B_IDLE, B_EXT, B_BRK}
// - Sub-module ps2_rx: synchroniser, edge detector, shift register, parity/stop check and timeout watchdog.
//   It outputs byte[7:0], byte_vld and frame_err.
// - This module keeps the byte FSM and the output registers.
// TESTING
// 1. Frame 5A (parity 1) -> 2 cycles after the stop edge: o_key=5A, o_ext=0, one o_make pulse.
// 2. E0 75 -> o_key=75, o_ext=1. Then E0 F0 75 -> o_key=00, o_ext=0, one o_break pulse.
// 3. Frame 72 with the parity bit flipped -> one o_frame_err pulse; o_key unchanged; no o_make.
// 4. Send 5 bits, stall for TIMEOUT_CYC+1 cycles, then a full frame 76 -> o_key=76; no o_frame_err.
// 5. Make 75, make 72, F0 75 -> o_key=72 throughout; o_break pulses once. Then F0 72 -> o_key=00.
// 6. Assert i_rst during bit 6 of a frame -> all outputs 0 next cycle. Release, send 5A -> o_key=5A.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 scan-code constants and byte-FSM state type shared by the keyboard decoder.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  typedef enum logic [1:0] {B_IDLE, B_EXT, B_BRK} byte_state_t;
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronises the PS/2 lines and receives 11-bit frames into checked bytes.
module ps2_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_frame_err
);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q, vld_q, err_q;
  logic [3:0]             cnt_q;
  logic [8:0]             sh_q;
  logic [7:0]             byte_q;
  logic [WW-1:0]          wd_q;
  logic                   fall, dat, timeout;
  assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign dat     = dat_sync_q[SYNC_STAGES-1];
  assign timeout = cnt_q != 4'd0 && !fall && wd_q == WW'(TIMEOUT_CYC - 1);
  assign o_byte      = byte_q;
  assign o_byte_vld  = vld_q;
  assign o_frame_err = err_q;
  // sh_q collects data bits LSB first with the parity bit ending up in sh_q[8]
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      cnt_q      <= 4'd0;
      sh_q       <= '0;
      byte_q     <= '0;
      wd_q       <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], i_ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      wd_q       <= (fall || cnt_q == 4'd0) ? '0 : wd_q + WW'(1);
      if (timeout) cnt_q <= 4'd0;
      else if (fall) begin
        if (cnt_q == 4'd0) cnt_q <= dat ? 4'd0 : 4'd1;
        else if (cnt_q == 4'd10) begin
          cnt_q <= 4'd0;
          if (dat && ^sh_q) begin
            byte_q <= sh_q[7:0];
            vld_q  <= 1'b1;
          end else err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 4'd1;
          sh_q  <= {dat, sh_q[8:1]};
        end
      end
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 bytes into a held scan code with make/break pulses.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_key,
  output logic       o_ext,
  output logic       o_make,
  output logic       o_break,
  output logic       o_frame_err
);
  logic [7:0]  rx_byte, key_q, key_d;
  logic        rx_vld, ign;
  logic        ext_q, ext_d, kext_q, kext_d, make_q, make_d, brk_q, brk_d;
  byte_state_t st_q, st_d;
  ps2_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .i_clk(i_clk), .i_rst(i_rst), .i_ps2_clk(i_ps2_clk), .i_ps2_data(i_ps2_data),
    .o_byte(rx_byte), .o_byte_vld(rx_vld), .o_frame_err(o_frame_err)
  );
  assign ign = rx_byte inside {PS2_PAUSE, PS2_ACK, PS2_BAT, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  always_comb begin
    st_d   = st_q;
    ext_d  = ext_q;
    key_d  = key_q;
    kext_d = kext_q;
    make_d = 1'b0;
    brk_d  = 1'b0;
    if (rx_vld && !ign) begin
      if (st_q == B_BRK) begin
        brk_d = 1'b1;
        st_d  = B_IDLE;
        ext_d = 1'b0;
        // only the release of the currently held key clears it; older keys are roll-over leftovers
        if (rx_byte == key_q && ext_q == kext_q) begin
          key_d  = 8'h00;
          kext_d = 1'b0;
        end
      end else if (rx_byte == PS2_BRK) st_d = B_BRK;
      else if (rx_byte == PS2_EXT) begin
        st_d  = B_EXT;
        ext_d = 1'b1;
      end else begin
        key_d  = rx_byte;
        kext_d = ext_q;
        make_d = 1'b1;
        st_d   = B_IDLE;
        ext_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q   <= B_IDLE;
      ext_q  <= 1'b0;
      key_q  <= 8'h00;
      kext_q <= 1'b0;
      make_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      ext_q  <= ext_d;
      key_q  <= key_d;
      kext_q <= kext_d;
      make_q <= make_d;
      brk_q  <= brk_d;
    end
  end
  assign o_key   = key_q;
  assign o_ext   = kext_q;
  assign o_make  = make_q;
  assign o_break = brk_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and randomized PS/2 frames checked against a scan-code model.
module tb_ps2_key_decoder;
  localparam int TO = 200;
  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] key;
  logic       ext, make, brk, ferr;
  int total = 0, bad = 0;
  int n_make = 0, n_brk = 0, n_err = 0;
  int e_make = 0, e_brk = 0, e_err = 0;
  logic [7:0] m_key = 8'h00;
  logic       m_ext = 1'b0, pend_e0 = 1'b0, pend_f0 = 1'b0;

  ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_key(key), .o_ext(ext), .o_make(make), .o_break(brk), .o_frame_err(ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (make) n_make++;
    if (brk)  n_brk++;
    if (ferr) n_err++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) return;
    if (pend_f0) begin
      e_brk++;
      if (b == m_key && pend_e0 == m_ext) begin m_key = 8'h00; m_ext = 1'b0; end
      pend_f0 = 1'b0;
      pend_e0 = 1'b0;
    end else if (b == 8'hF0) pend_f0 = 1'b1;
    else if (b == 8'hE0) pend_e0 = 1'b1;
    else begin
      m_key = b; m_ext = pend_e0; pend_e0 = 1'b0; e_make++;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic badpar);
    return {1'b1, ~^b ^ badpar, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input logic badpar);
    logic [10:0] f;
    f = frame(b, badpar);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    repeat (4) @(negedge clk);
    if (badpar) e_err++; else model_byte(b);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".key"}, key, m_key);
    check({tag, ".ext"}, ext, m_ext);
    check({tag, ".make"}, n_make, e_make);
    check({tag, ".brk"}, n_brk, e_brk);
    check({tag, ".err"}, n_err, e_err);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  keys [5];
    keys = '{8'h75, 8'h72, 8'h5A, 8'h76, 8'h1C};
    repeat (3) @(negedge clk);
    check("rst.key", key, 0);
    check("rst.outs", {ext, make, brk, ferr}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // 1: latency of 5A measured from the stop-bit falling edge on the pin
    f = frame(8'h5A, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("lat.early", key, 8'h00);
    @(negedge clk);
    check("lat.key", key, 8'h5A);
    check("lat.make", make, 1);
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    model_byte(8'h5A);
    check_all("t1");
    // 2: extended make and extended break
    send(8'hE0, 0); send(8'h75, 0); check_all("t2m");
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0); check_all("t2b");
    // 3: parity error
    send(8'h72, 1); check_all("t3");
    // 4: partial frame abandoned by the watchdog
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (TO + 1) @(negedge clk);
    send(8'h76, 0); check_all("t4");
    // 5: roll-over and typematic repeat
    send(8'h75, 0); send(8'h72, 0); check_all("t5a");
    send(8'hF0, 0); send(8'h75, 0); check_all("t5b");
    send(8'h72, 0); check_all("t5rep");
    send(8'hF0, 0); send(8'h72, 0); check_all("t5c");
    send(8'hFA, 0); send(8'hAA, 0); check_all("t5ign");
    // 6: reset in the middle of bit 6
    send(8'h76, 0);
    f = frame(8'h3C, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(f[i]);
    ps2_data = f[6];
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6.key", key, 0);
    check("t6.outs", {ext, make, brk, ferr}, 0);
    m_key = 8'h00; m_ext = 1'b0; pend_e0 = 1'b0; pend_f0 = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h5A, 0); check_all("t6");
    // randomized byte sequences
    for (int n = 0; n < 40; n++) begin
      automatic int op = $urandom_range(0, 9);
      automatic logic [7:0] k = keys[$urandom_range(0, 4)];
      automatic logic e = $urandom_range(0, 2) == 0;
      if (op < 4) begin
        if (e) send(8'hE0, 0);
        send(k, 0);
      end else if (op < 7) begin
        if (e) send(8'hE0, 0);
        send(8'hF0, 0);
        send($urandom_range(0, 1) ? m_key : k, 0);
      end else if (op == 7) send(8'($urandom), 0);
      else if (op == 8) send(8'($urandom), 1);
      else send(8'hFA, 0);
      check_all("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
